// File: rtl/qspi_rx_shifter.sv
// QSPI receive deserializer: samples 1/2/4 IO lanes per SCK strobe into bytes.
// Optional LSB-first assembly when QSPI_RX_LSB_FIRST_EN is defined.
module qspi_rx_shifter #(
  parameter int unsigned LenW      = 16,
  parameter logic [7:0]  ResetData = 8'h00
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [LenW-1:0] len_i,
  input  logic [1:0]      mode_i,
`ifdef QSPI_RX_LSB_FIRST_EN
  input  logic            lsb_first_i,
`endif
  input  logic            sample_i,
  input  logic [3:0]      io_i,
  output logic [7:0]      data_o,
  output logic            data_en_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            den_q, den_d;
  logic            done_q, done_d;

  logic [7:0]      sh_nxt;
  logic [3:0]      step;
  logic [3:0]      cnt_sum;

`ifdef QSPI_RX_LSB_FIRST_EN
  logic            lsb_q, lsb_d;
`endif

  // Mode 3 is reserved and falls back to single-lane.
  always_comb begin
    step   = 4'd1;
    sh_nxt = {sh_q[6:0], io_i[1]};
    unique case (1'b1)
      (mode_q == 2'd2): begin
        step   = 4'd4;
        sh_nxt = {sh_q[3:0], io_i[3:0]};
      end
      (mode_q == 2'd1): begin
        step   = 4'd2;
        sh_nxt = {sh_q[5:0], io_i[1:0]};
      end
      default: ;
    endcase
`ifdef QSPI_RX_LSB_FIRST_EN
    if (lsb_q) begin
      unique case (1'b1)
        (mode_q == 2'd2): sh_nxt = {io_i[3:0], sh_q[7:4]};
        (mode_q == 2'd1): sh_nxt = {io_i[1:0], sh_q[7:2]};
        default:          sh_nxt = {io_i[1], sh_q[7:1]};
      endcase
    end
`endif
  end

  // Carry out of the 3-bit counter marks byte completion.
  assign cnt_sum = {1'b0, cnt_q} + step;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    den_d   = 1'b0;
    done_d  = 1'b0;
`ifdef QSPI_RX_LSB_FIRST_EN
    lsb_d   = lsb_q;
`endif
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      sh_d    = 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state_d = SHIFT;
              len_d   = len_i;
              mode_d  = mode_i;
              sh_d    = 8'h00;
              cnt_d   = 3'd0;
`ifdef QSPI_RX_LSB_FIRST_EN
              lsb_d   = lsb_first_i;
`endif
            end else begin
              done_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          if (sample_i) begin
            sh_d  = sh_nxt;
            cnt_d = cnt_sum[2:0];
            if (cnt_sum[3]) begin
              data_d = sh_nxt;
              den_d  = 1'b1;
              len_d  = len_q - 1'b1;
              if (len_q == {{(LenW-1){1'b0}}, 1'b1}) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      mode_q  <= 2'd0;
      sh_q    <= 8'h00;
      cnt_q   <= 3'd0;
      data_q  <= ResetData;
      den_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      den_q   <= den_d;
      done_q  <= done_d;
    end
  end

`ifdef QSPI_RX_LSB_FIRST_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lsb_q <= 1'b0;
    else         lsb_q <= lsb_d;
  end
`endif

  assign data_o    = data_q;
  assign data_en_o = den_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q == SHIFT);

endmodule
